// File: rtl/iq_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : iq_frame_deser
//  Description : Deserializer for the time-multiplexed I/Q result stream from
//                the down-converter/CIC chain. A strobe burst carries one
//                frame of interleaved I0,Q0,...,I(N_CH-1),Q(N_CH-1). The frame
//                is published on all channels at once. The block also flags
//                framing errors and overruns, counts frames, and provides a
//                valid/ack handshake with optional hold protection.
//  Ports       : clk_adc     - sample clock (rising edge)
//                reset       - synchronous, active-low reset
//                strobe_in   - stream_in carries a valid frame word
//                stream_in   - DW-bit signed word stream
//                hold        - protect an unacknowledged frame from overwrite
//                frame_ack   - consumer has read the current frame (pulse)
//                clear_err   - clear sticky overrun/frame_err (pulse)
//                i_out/q_out - channel k at bits [k*DW +: DW]
//                strobe_out  - one-cycle pulse per accepted frame
//                frame_valid - published frame not yet acknowledged
//                overrun     - sticky, frame arrived while frame_valid=1
//                frame_err   - sticky, short or long burst seen
//                frame_cnt   - count of published frames (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_frame_deser #(
  parameter int DW    = 21,
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_adc,
  input  logic                 reset,
  input  logic                 strobe_in,
  input  logic [DW-1:0]        stream_in,
  input  logic                 hold,
  input  logic                 frame_ack,
  input  logic                 clear_err,
  output logic [N_CH*DW-1:0]   i_out,
  output logic [N_CH*DW-1:0]   q_out,
  output logic                 strobe_out,
  output logic                 frame_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int c_NW = 2 * N_CH;
  localparam int c_IW = (c_NW > 2) ? $clog2(c_NW) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_IW-1:0]    r_idx;
  // The final word of a frame is never stored; it is taken straight from
  // stream_in at the publish edge.
  logic [DW-1:0]      r_sh [c_NW-1];
  logic               r_drain_first;

  logic               w_last;
  logic               w_pub;
  logic               w_short;
  logic               w_long;
  logic               w_block;
  logic               w_accept;
  logic               w_ovr_set;
  logic               w_wr;
  logic [N_CH*DW-1:0] w_i_new;
  logic [N_CH*DW-1:0] w_q_new;

  assign w_last    = (r_idx == c_LAST);
  assign w_pub     = (r_state == S_COLLECT) && strobe_in && w_last;
  assign w_short   = (r_state == S_COLLECT) && !strobe_in;
  assign w_long    = (r_state == S_DRAIN) && r_drain_first && strobe_in;
  // An ack on the publish edge acknowledges the old frame, so it unblocks.
  assign w_block   = frame_valid && !frame_ack && hold;
  assign w_accept  = w_pub && !w_block;
  assign w_ovr_set = w_pub && frame_valid && !frame_ack;
  assign w_wr      = strobe_in &&
                     ((r_state == S_IDLE) || ((r_state == S_COLLECT) && !w_last));

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_chan
      assign w_i_new[k*DW +: DW] = r_sh[2*k];
      if (k == N_CH - 1) begin : g_q_last
        assign w_q_new[k*DW +: DW] = stream_in;
      end else begin : g_q_shadow
        assign w_q_new[k*DW +: DW] = r_sh[2*k+1];
      end
    end
  endgenerate

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (strobe_in) w_next = S_COLLECT;
      S_COLLECT: begin
        if (!strobe_in)  w_next = S_IDLE;
        else if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN:   if (!strobe_in) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Index is zero whenever no frame is being collected, so IDLE always
  // writes slot 0.
  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      r_idx <= '0;
      for (int w = 0; w < c_NW - 1; w++) r_sh[w] <= '0;
    end else begin
      r_idx <= w_wr ? r_idx + 1'b1 : '0;
      for (int w = 0; w < c_NW - 1; w++) begin
        if (w_wr && (r_idx == c_IW'(w))) r_sh[w] <= stream_in;
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      i_out         <= '0;
      q_out         <= '0;
      strobe_out    <= 1'b0;
      frame_valid   <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
      r_drain_first <= 1'b0;
    end else begin
      strobe_out    <= w_accept;
      r_drain_first <= w_pub;
      if (w_accept) begin
        i_out     <= w_i_new;
        q_out     <= w_q_new;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (w_accept)       frame_valid <= 1'b1;
      else if (frame_ack) frame_valid <= 1'b0;
      // Set has priority over clear on the sticky flags.
      if (w_ovr_set)      overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
      if (w_short || w_long) frame_err <= 1'b1;
      else if (clear_err)    frame_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_frame_deser
//  Description : Self-checking bench for iq_frame_deser. Directed scenarios
//                followed by randomized bursts, compared against a frame-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_frame_deser;

  localparam int DW    = 21;
  localparam int N_CH  = 4;
  localparam int CNT_W = 2;
  localparam int NW    = 2 * N_CH;

  logic                clk_adc;
  logic                reset;
  logic                strobe_in;
  logic [DW-1:0]       stream_in;
  logic                hold;
  logic                frame_ack;
  logic                clear_err;
  logic [N_CH*DW-1:0]  i_out;
  logic [N_CH*DW-1:0]  q_out;
  logic                strobe_out;
  logic                frame_valid;
  logic                overrun;
  logic                frame_err;
  logic [CNT_W-1:0]    frame_cnt;

  iq_frame_deser #(.DW(DW), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_adc     (clk_adc),
    .reset       (reset),
    .strobe_in   (strobe_in),
    .stream_in   (stream_in),
    .hold        (hold),
    .frame_ack   (frame_ack),
    .clear_err   (clear_err),
    .i_out       (i_out),
    .q_out       (q_out),
    .strobe_out  (strobe_out),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk_adc = 1'b0;
  always #5 clk_adc = ~clk_adc;

  // Reference model state (frame-level view).
  logic [DW-1:0] m_i [N_CH];
  logic [DW-1:0] m_q [N_CH];
  int            m_cnt;
  bit            m_valid, m_ovr, m_err;
  int            m_stb;
  int            n_stb;
  logic [DW-1:0] words [32];
  int            checks, errors;

  always @(posedge clk_adc) if (strobe_out === 1'b1) n_stb++;

  task automatic chk(input string tag, input logic [N_CH*DW-1:0] obs,
                     input logic [N_CH*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N_CH*DW-1:0] ei, eq;
    logic [31:0] c;
    @(negedge clk_adc);
    for (int k = 0; k < N_CH; k++) begin
      ei[k*DW +: DW] = m_i[k];
      eq[k*DW +: DW] = m_q[k];
    end
    c = m_cnt;
    chk({tag, ".i_out"}, i_out, ei);
    chk({tag, ".q_out"}, q_out, eq);
    chk({tag, ".frame_valid"}, frame_valid, m_valid);
    chk({tag, ".overrun"}, overrun, m_ovr);
    chk({tag, ".frame_err"}, frame_err, m_err);
    chk({tag, ".frame_cnt"}, frame_cnt, c[CNT_W-1:0]);
    chk({tag, ".strobe_count"}, n_stb, m_stb);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_i[k] = '0;
      m_q[k] = '0;
    end
    m_cnt = 0; m_valid = 0; m_ovr = 0; m_err = 0;
  endtask

  // Drives an n-word burst then one low cycle; ack_last pulses frame_ack with
  // the last frame word.
  task automatic burst(input int n, input bit ack_last);
    bit seen, acc;
    seen = 0;
    acc  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_adc);
      if (i == NW) seen = strobe_out;
      strobe_in = 1'b1;
      stream_in = words[i];
      frame_ack = ack_last && (i == NW - 1);
    end
    @(negedge clk_adc);
    if (n == NW) seen = strobe_out;
    strobe_in = 1'b0;
    frame_ack = 1'b0;
    if (n < NW) begin
      m_err = 1;
    end else begin
      if (m_valid && !ack_last && hold) begin
        m_ovr = 1;
      end else begin
        if (m_valid && !ack_last) m_ovr = 1;
        for (int k = 0; k < N_CH; k++) begin
          m_i[k] = words[2*k];
          m_q[k] = words[2*k+1];
        end
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_valid = 1;
        m_stb++;
        acc = 1;
      end
      if (n > NW) m_err = 1;
      chk("strobe_timing", seen, acc);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk_adc); frame_ack = 1'b1;
    @(negedge clk_adc); frame_ack = 1'b0;
    m_valid = 0;
  endtask

  task automatic clr_pulse();
    @(negedge clk_adc); clear_err = 1'b1;
    @(negedge clk_adc); clear_err = 1'b0;
    m_err = 0; m_ovr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_adc); reset = 1'b0;
    @(negedge clk_adc); reset = 1'b1;
    model_reset();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) words[i] = DW'($urandom);
  endtask

  initial begin
    checks = 0; errors = 0; m_stb = 0; n_stb = 0;
    reset = 1'b0; strobe_in = 1'b0; stream_in = '0; hold = 1'b0;
    frame_ack = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_adc);
    reset = 1'b1;
    check_all("reset");

    // Basic frame 1..8.
    for (int i = 0; i < 32; i++) words[i] = DW'(i + 1);
    burst(NW, 1'b0);
    check_all("basic");

    // Negative / positive full scale.
    ack_pulse();
    for (int i = 0; i < 32; i++) words[i] = (i % 2 == 0) ? DW'(1 << (DW-1)) : DW'((1 << (DW-1)) - 1);
    burst(NW, 1'b0);
    check_all("fullscale");
    for (int k = 0; k < N_CH; k++) begin
      chk("sign_i", i_out[k*DW + DW - 1], 1'b1);
      chk("sign_q", q_out[k*DW + DW - 1], 1'b0);
    end

    // Short burst, then a valid frame.
    ack_pulse();
    fill_rand();
    burst(5, 1'b0);
    check_all("short");
    fill_rand();
    burst(NW, 1'b0);
    check_all("after_short");

    // Long burst running straight into a second frame, then a normal frame.
    clr_pulse();
    ack_pulse();
    fill_rand();
    burst(NW + 10, 1'b0);
    check_all("long");
    fill_rand();
    burst(NW, 1'b0);
    check_all("after_long");

    // Hold protects frame A; without hold B overwrites.
    clr_pulse();
    ack_pulse();
    hold = 1'b1;
    fill_rand();
    burst(NW, 1'b0);
    fill_rand();
    burst(NW, 1'b0);
    check_all("hold_AB");
    hold = 1'b0;
    burst(NW, 1'b0);
    check_all("nohold_B");
    clr_pulse();
    check_all("clear_err");

    // Ack on the publish edge, with and without hold.
    fill_rand();
    burst(NW, 1'b1);
    check_all("ack_coincident");
    hold = 1'b1;
    fill_rand();
    burst(NW, 1'b1);
    check_all("ack_coincident_hold");
    hold = 1'b0;

    // Counter wrap after reset.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      burst(NW, 1'b1);
    end
    check_all("wrap");

    // Reset in the middle of a burst.
    fill_rand();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_adc);
      strobe_in = 1'b1;
      stream_in = words[i];
    end
    @(negedge clk_adc);
    reset = 1'b0;
    strobe_in = 1'b0;
    model_reset();
    check_all("midreset");
    reset = 1'b1;
    fill_rand();
    burst(NW, 1'b0);
    check_all("after_midreset");

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      hold = 1'($urandom);
      fill_rand();
      burst($urandom_range(1, NW + 4), 1'($urandom));
      if ($urandom_range(0, 2) == 0) ack_pulse();
      if ($urandom_range(0, 3) == 0) clr_pulse();
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_frame_deser.md
Name: iq_frame_deser

Overview:
- Parametrised deserializer for the time-multiplexed I/Q result stream leaving the VVM down-converter/CIC chain.
- Collects one frame of N_CH interleaved I/Q words per strobe burst and publishes all channels in parallel, atomically.
- Adds framing-error detection, a frame counter, and a valid/ack readout handshake with optional hold and overrun flag.
- Sits between the DDC/CIC output and the phase/magnitude processing and CSR readout logic.

Parameters:
- DW, 21, width of each I or Q word (signed).
- N_CH, 4, number of channels per frame; 1..8.
- CNT_W, 16, width of frame counter.

Ports:
- clk_adc  input  1  sample clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- strobe_in  input  1  high while stream_in carries valid frame words.
- stream_in  input  DW  words in order I0,Q0,I1,Q1,…,I(N_CH-1),Q(N_CH-1).
- hold  input  1  when 1, an unacknowledged frame is protected from overwrite.
- frame_ack  input  1  one-cycle pulse; consumer has read the current outputs.
- clear_err  input  1  one-cycle pulse; clears the sticky error flags.
- i_out  output  N_CH*DW  channel k I at bits [k*DW +: DW].
- q_out  output  N_CH*DW  channel k Q at bits [k*DW +: DW].
- strobe_out  output  1  one-cycle pulse when new data is published.
- frame_valid  output  1  level; published frame not yet acknowledged.
- overrun  output  1  sticky; a frame arrived while frame_valid was 1.
- frame_err  output  1  sticky; a short or long burst was detected.
- frame_cnt  output  CNT_W  count of published frames; wraps at 2^CNT_W.

Behaviour:
- Reset: while reset=0 at a clock edge, all outputs go to 0, FSM goes to IDLE, word index goes to 0, and shadow registers clear. A reset mid-frame discards the partial frame.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - strobe_in=1 samples word 0 (I0) into shadow, sets idx=1, and goes to COLLECT.
  - A frame can start only from IDLE.
- COLLECT:
  - Each cycle with strobe_in=1 stores stream_in at word idx and increments idx.
  - strobe_in=0 before idx reaches 2*N_CH (short burst): discard the frame, set frame_err, go to IDLE. The cycle with strobe_in=0 is not stored.
  - The cycle that samples word 2*N_CH-1 (Q of last channel) is the publish edge; go to DRAIN.
- DRAIN:
  - Stays in DRAIN while strobe_in=1.
  - If strobe_in=1 in the first DRAIN cycle (long burst), set frame_err. Extra words are ignored; the already-published frame stands.
  - strobe_in=0 returns to IDLE.
  - Minimum gap between frames is therefore 1 low cycle.
- Publish at the publish edge:
  - If frame_valid=1, no frame_ack this cycle, and hold=1:
    - i_out/q_out are not updated, frame_cnt is not incremented, strobe_out is not pulsed.
    - overrun is set and the frame is dropped.
  - Otherwise:
    - i_out/q_out load all channels simultaneously, taking the last word directly from stream_in.
    - frame_cnt increments with wrap.
    - frame_valid is set.
    - overrun is set if frame_valid was 1 and no ack was present.
  - strobe_out is registered: it is high in the cycle after the publish edge, for exactly 1 cycle, only for accepted frames.
  - Latency: outputs change at the edge sampling the last word; strobe_out follows 1 cycle later with the outputs already stable.
- frame_ack:
  - Clears frame_valid.
  - Ack coinciding with a publish counts as acknowledging the old frame: new frame accepted, frame_valid stays 1, no overrun.
  - Ack when frame_valid=0 has no effect.
- clear_err clears overrun and frame_err. If a set event occurs in the same cycle, set wins.
- Outputs hold their value between publishes. No combinational path from inputs to outputs.

Test Plan:
- Reset and basic frame (N_CH=4, DW=21):
  - Release reset, then burst 8 words 1..8 with hold=0.
  - Required: i_out={7,5,3,1}, q_out={8,6,4,2} (channel 0 in the LSB slice).
  - Required: strobe_out pulses once, 1 cycle after word 8; frame_cnt=1; frame_valid=1.
- Negative full scale:
  - Frame carrying -2^20 and 2^20-1 in every slot.
  - Required: sign bits preserved in each slice.
- Short burst:
  - 5 words, then strobe_in low.
  - Required: outputs unchanged, no strobe_out, frame_err=1, frame_cnt unchanged.
  - Then send a valid frame: required to publish normally.
- Long burst:
  - 10 words.
  - Required: first 8 published, frame_err=1.
  - Required: the next frame starting without a low gap is ignored; a frame after 1 low cycle is accepted.
- Hold/overrun:
  - hold=1, two frames (A then B) with no ack.
  - Required: outputs stay at A, overrun=1, frame_cnt=1.
  - Repeat with hold=0: required: outputs become B, frame_cnt=2, overrun=1.
  - clear_err: required to clear overrun.
- Ack coincident with publish, plus wrap and mid-frame reset:
  - Ack on the publish edge: required: frame_valid stays 1, no overrun.
  - CNT_W=2, 4 frames: required: frame_cnt wraps to 0.
  - reset=0 mid-burst: required: all outputs 0, FSM in IDLE.
